sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 182 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: reads a SPRITE_W x SPRITE_H sprite from a latency-ROM in raster order
// and emits clipped, non-transparent pixels to the LCD with ready/valid backpressure.
module sprite_blitter #(
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 32,
    parameter int          SCREEN_W    = 240,
    parameter int          SCREEN_H    = 320,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter int          ROM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  spriteId,
    input  logic [7:0]  xOrigin,
    input  logic [8:0]  yOrigin,
    input  logic        flipX,
    output logic [3:0]  ROMId,
    output logic [15:0] ROMAddr,
    input  logic [15:0] readData,
    output logic        pixelWrite,
    output logic [7:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic [15:0] pixelData,
    input  logic        pixelReady,
    output logic        busy,
    output logic        done
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int LAT_W = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(SPRITE_H - 1);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(ROM_LATENCY);
    localparam logic [8:0]       X_LIMIT    = 9'(SCREEN_W);
    localparam logic [9:0]       Y_LIMIT    = 10'(SCREEN_H);
    localparam logic [15:0]      ROW_STRIDE = 16'(SPRITE_W);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, NEXT, DONE} state_t;

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt, col_eff;
    logic [ROW_W-1:0] row, row_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic [7:0]       x_org, x_org_nxt;
    logic [8:0]       y_org, y_org_nxt;
    logic             flip, flip_nxt;
    logic [3:0]       rom_id_nxt;
    logic [15:0]      rom_addr_nxt, addr_calc;
    logic             pixel_write_nxt, busy_nxt, done_nxt;
    logic [7:0]       pixel_x_nxt;
    logic [8:0]       pixel_y_nxt;
    logic [15:0]      pixel_data_nxt;
    logic [8:0]       x_sum;
    logic [9:0]       y_sum;
    logic             skip;

    // Sums are one bit wider than the origins so off-screen pixels cannot wrap back on.
    assign col_eff   = flip ? (COL_LAST - col) : col;
    assign addr_calc = 16'(row) * ROW_STRIDE + 16'(col_eff);
    assign x_sum     = {1'b0, x_org} + 9'(col);
    assign y_sum     = {1'b0, y_org} + 10'(row);
    assign skip      = (readData == TRANSPARENT) || (x_sum >= X_LIMIT) || (y_sum >= Y_LIMIT);

    always_comb begin
        // NOTE: every next-value defaults to its current value first, so no path infers a latch.
        state_nxt       = state;
        col_nxt         = col;
        row_nxt         = row;
        lat_cnt_nxt     = lat_cnt;
        x_org_nxt       = x_org;
        y_org_nxt       = y_org;
        flip_nxt        = flip;
        rom_id_nxt      = ROMId;
        rom_addr_nxt    = ROMAddr;
        pixel_write_nxt = pixelWrite;
        pixel_x_nxt     = pixelX;
        pixel_y_nxt     = pixelY;
        pixel_data_nxt  = pixelData;
        busy_nxt        = busy;
        done_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    rom_id_nxt = spriteId;
                    x_org_nxt  = xOrigin;
                    y_org_nxt  = yOrigin;
                    flip_nxt   = flipX;
                    col_nxt    = '0;
                    row_nxt    = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                rom_addr_nxt = addr_calc;
                lat_cnt_nxt  = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    pixel_data_nxt = readData;
                    if (skip) begin
                        state_nxt = NEXT;
                    end else begin
                        pixel_write_nxt = 1'b1;
                        pixel_x_nxt     = x_sum[7:0];
                        pixel_y_nxt     = y_sum[8:0];
                        state_nxt       = WRITE;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt + LAT_W'(1);
                end
            end
            WRITE: begin
                if (pixelReady) begin
                    pixel_write_nxt = 1'b0;
                    state_nxt       = NEXT;
                end
            end
            NEXT: begin
                state_nxt = FETCH;
                if (col == COL_LAST) begin
                    col_nxt = '0;
                    if (row == ROW_LAST) begin
                        row_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        row_nxt = row + ROW_W'(1);
                    end
                end else begin
                    col_nxt = col + COL_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an asynchronous reset that clears everything at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            lat_cnt    <= '0;
            x_org      <= '0;
            y_org      <= '0;
            flip       <= 1'b0;
            ROMId      <= '0;
            ROMAddr    <= '0;
            pixelWrite <= 1'b0;
            pixelX     <= '0;
            pixelY     <= '0;
            pixelData  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            lat_cnt    <= lat_cnt_nxt;
            x_org      <= x_org_nxt;
            y_org      <= y_org_nxt;
            flip       <= flip_nxt;
            ROMId      <= rom_id_nxt;
            ROMAddr    <= rom_addr_nxt;
            pixelWrite <= pixel_write_nxt;
            pixelX     <= pixel_x_nxt;
            pixelY     <= pixel_y_nxt;
            pixelData  <= pixel_data_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a 2-stage ROM model returns the address as data and
// a monitor records every transferred pixel, ROM address change and done pulse.
module tb_sprite_blitter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  spriteId = '0;
    logic [7:0]  xOrigin = '0;
    logic [8:0]  yOrigin = '0;
    logic        flipX = 1'b0;
    logic [3:0]  ROMId;
    logic [15:0] ROMAddr;
    logic [15:0] readData;
    logic        pixelWrite;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;
    logic        pixelReady = 1'b1;
    logic        busy;
    logic        done;

    sprite_blitter dut (
        .clock(clock), .reset(reset), .start(start), .spriteId(spriteId),
        .xOrigin(xOrigin), .yOrigin(yOrigin), .flipX(flipX),
        .ROMId(ROMId), .ROMAddr(ROMAddr), .readData(readData),
        .pixelWrite(pixelWrite), .pixelX(pixelX), .pixelY(pixelY),
        .pixelData(pixelData), .pixelReady(pixelReady), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // ROM reader with a latency of two edges; optionally returns only the transparent colour.
    logic [15:0] rom_d1 = '0, rom_d2 = '0;
    logic        transp = 1'b0;
    always @(posedge clock) begin
        rom_d1 <= ROMAddr;
        rom_d2 <= rom_d1;
    end
    assign readData = transp ? 16'hF81F : rom_d2;

    typedef struct packed {logic [7:0] x; logic [8:0] y; logic [15:0] d;} wr_t;

    wr_t         wq[$];
    logic [15:0] aq[$];
    int          addr_chg = 0, done_cnt = 0, addr_at_done = -1;
    logic [15:0] prev_addr = '0;
    int          checks = 0, errors = 0;

    always @(posedge clock) begin
        if (reset) begin
            if (pixelWrite && pixelReady) wq.push_back({pixelX, pixelY, pixelData});
            if (ROMAddr !== prev_addr) begin
                addr_chg++;
                if (aq.size() < 16) aq.push_back(ROMAddr);
            end
            if (done) begin
                done_cnt++;
                addr_at_done = addr_chg;
            end
        end
        prev_addr = ROMAddr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        aq.delete();
        addr_chg     = 0;
        done_cnt     = 0;
        addr_at_done = -1;
    endtask

    task automatic pulse_start(input logic [3:0] id, input logic [7:0] x, input logic [8:0] y,
                               input logic f);
        spriteId = id;
        xOrigin  = x;
        yOrigin  = y;
        flipX    = f;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 6000) begin
            tick(1);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        tick(3);
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    function automatic wr_t wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return '1;
    endfunction

    function automatic logic [15:0] aq_at(input int i);
        if (i < aq.size()) return aq[i];
        return 16'hFFFF;
    endfunction

    // Mismatches against the raster-order model of an unclipped sprite.
    function automatic int order_errs(input logic [7:0] ox, input logic [8:0] oy, input logic f);
        int n = 0;
        for (int i = 0; i < wq.size() && i < 512; i++) begin
            int  c = i % 16;
            int  r = i / 16;
            int  a = r * 16 + (f ? 15 - c : c);
            wr_t e = {8'(int'(ox) + c), 9'(int'(oy) + r), 16'(a)};
            if (wq[i] !== e) n++;
        end
        return n;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_pw"},    64'(pixelWrite), 64'd0);
        check({tag, "_romid"}, 64'(ROMId), 64'd0);
        check({tag, "_addr"},  64'(ROMAddr), 64'd0);
        check({tag, "_px"},    64'(pixelX), 64'd0);
        check({tag, "_py"},    64'(pixelY), 64'd0);
        check({tag, "_pd"},    64'(pixelData), 64'd0);
    endtask

    initial begin
        int   n;
        int   stab;
        int   mism;
        wr_t  cap;

        // Reset state and quiet idle after release.
        tick(3);
        check_outputs_zero("rst");
        @(negedge clock);
        reset = 1'b1;
        tick(10);
        check("idle_no_writes", 64'(wq.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Plain draw at (10,20).
        clear_mon();
        pulse_start(4'd3, 8'd10, 9'd20, 1'b0);
        wait_done("r1");
        check("r1_writes", 64'(wq.size()), 64'd512);
        check("r1_order", 64'(order_errs(8'd10, 9'd20, 1'b0)), 64'd0);
        check("r1_first", 64'(wq_at(0)), 64'({8'd10, 9'd20, 16'h0000}));
        check("r1_last", 64'(wq_at(511)), 64'({8'd25, 9'd51, 16'h01FF}));
        check("r1_romid", 64'(ROMId), 64'd3);

        // Mirrored draw.
        clear_mon();
        pulse_start(4'd3, 8'd10, 9'd20, 1'b1);
        wait_done("r2");
        mism = 0;
        for (int i = 0; i < 16; i++) if (aq_at(i) !== 16'(15 - i)) mism++;
        check("r2_row0_addr", 64'(mism), 64'd0);
        check("r2_reads", 64'(addr_chg), 64'd512);
        check("r2_writes", 64'(wq.size()), 64'd512);
        check("r2_first", 64'(wq_at(0)), 64'({8'd10, 9'd20, 16'd15}));
        check("r2_order", 64'(order_errs(8'd10, 9'd20, 1'b1)), 64'd0);

        // Clipped at the bottom-right corner.
        clear_mon();
        pulse_start(4'd3, 8'd230, 9'd310, 1'b0);
        wait_done("r3");
        check("r3_writes", 64'(wq.size()), 64'd100);
        check("r3_reads", 64'(addr_chg), 64'd512);
        check("r3_first", 64'(wq_at(0)), 64'({8'd230, 9'd310, 16'd0}));
        check("r3_last", 64'(wq_at(99)), 64'({8'd239, 9'd319, 16'd153}));

        // Fully transparent sprite.
        transp = 1'b1;
        clear_mon();
        pulse_start(4'd3, 8'd10, 9'd20, 1'b0);
        wait_done("r4");
        check("r4_writes", 64'(wq.size()), 64'd0);
        check("r4_reads_at_done", 64'(addr_at_done), 64'd512);
        transp = 1'b0;

        // Backpressure on the first pixel plus an ignored start while busy.
        pixelReady = 1'b0;
        clear_mon();
        pulse_start(4'd3, 8'd10, 9'd20, 1'b0);
        n = 0;
        while (!pixelWrite && n < 100) begin
            tick(1);
            n++;
        end
        check("bp_write_seen", 64'(pixelWrite), 64'd1);
        cap = {pixelX, pixelY, pixelData};
        check("bp_first", 64'(cap), 64'({8'd10, 9'd20, 16'd0}));
        check("bp_romid", 64'(ROMId), 64'd3);
        stab = 0;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            if (k == 2) begin
                spriteId = 4'd9;
                xOrigin  = 8'd100;
                yOrigin  = 9'd5;
                flipX    = 1'b1;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!pixelWrite || {pixelX, pixelY, pixelData} !== cap) stab++;
        end
        start = 1'b0;
        check("bp_stable", 64'(stab), 64'd0);
        check("bp_no_xfer", 64'(wq.size()), 64'd0);
        pixelReady = 1'b1;
        wait_done("bp");
        check("bp_writes", 64'(wq.size()), 64'd512);
        check("bp_order", 64'(order_errs(8'd10, 9'd20, 1'b0)), 64'd0);
        check("bp_romid_end", 64'(ROMId), 64'd3);

        // Reset while pixel 100 is being presented.
        clear_mon();
        pulse_start(4'd3, 8'd10, 9'd20, 1'b0);
        n = 0;
        while (!(pixelWrite && wq.size() == 100) && n < 2000) begin
            tick(1);
            n++;
        end
        check("rw_reached", 64'(pixelWrite && wq.size() == 100), 64'd1);
        check("rw_px", 64'({pixelX, pixelY}), 64'({8'd14, 9'd26}));
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("rw");
        clear_mon();
        tick(2);
        @(negedge clock);
        reset = 1'b1;
        tick(20);
        check("rw_no_writes", 64'(wq.size()), 64'd0);
        check("rw_no_reads", 64'(addr_chg), 64'd0);
        check("rw_busy", 64'(busy), 64'd0);

        // Fresh draw after the reset starts from row 0, col 0.
        clear_mon();
        pulse_start(4'd3, 8'd50, 9'd60, 1'b0);
        wait_done("rs");
        check("rs_first", 64'(wq_at(0)), 64'({8'd50, 9'd60, 16'd0}));
        check("rs_writes", 64'(wq.size()), 64'd512);
        check("rs_order", 64'(order_errs(8'd50, 9'd60, 1'b0)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
